// File: rtl/music_pkg.sv
// Shared note codes, LED patterns, buffer depth and FSM state encoding
// for the melody recorder.
package music_pkg;

  // Note codes: 0 is a rest, 1..7 are the seven keys.
  localparam logic [3:0] music0 = 4'd0;
  localparam logic [3:0] music1 = 4'd1;
  localparam logic [3:0] music2 = 4'd2;
  localparam logic [3:0] music3 = 4'd3;
  localparam logic [3:0] music4 = 4'd4;
  localparam logic [3:0] music5 = 4'd5;
  localparam logic [3:0] music6 = 4'd6;
  localparam logic [3:0] music7 = 4'd7;

  // Terminates a recording; also returned for reads past the end.
  localparam logic [3:0] END_MARK = 4'b1111;

  // One-hot LED echo per note; led8 is the all-off pattern for rests.
  localparam logic [6:0] led1 = 7'b0000001;
  localparam logic [6:0] led2 = 7'b0000010;
  localparam logic [6:0] led3 = 7'b0000100;
  localparam logic [6:0] led4 = 7'b0001000;
  localparam logic [6:0] led5 = 7'b0010000;
  localparam logic [6:0] led6 = 7'b0100000;
  localparam logic [6:0] led7 = 7'b1000000;
  localparam logic [6:0] led8 = 7'b0000000;

  // Buffer depth in entries, including the end-marker slot.
  localparam int SONG_TIME = 56;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    CAPTURE    = 2'd2,
    FINISH     = 2'd3
  } state_t;

  // Lowest set key wins; no key pressed encodes as a rest.
  function automatic logic [3:0] encode_note(input logic [6:0] keys);
    logic [3:0] note;
    if (keys[0])      note = music1;
    else if (keys[1]) note = music2;
    else if (keys[2]) note = music3;
    else if (keys[3]) note = music4;
    else if (keys[4]) note = music5;
    else if (keys[5]) note = music6;
    else if (keys[6]) note = music7;
    else              note = music0;
    return note;
  endfunction

  // LED pattern for a note code; rests and markers light nothing.
  function automatic logic [6:0] note_to_led(input logic [3:0] note);
    logic [6:0] led;
    case (note)
      music1:  led = led1;
      music2:  led = led2;
      music3:  led = led3;
      music4:  led = led4;
      music5:  led = led5;
      music6:  led = led6;
      music7:  led = led7;
      default: led = led8;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/record_buffer.sv
// Song storage: one write port and one registered read port.
// Reads return the old contents when the same address is written in
// the same cycle. Contents are not reset.
module record_buffer #(
  parameter int DEPTH = 56,
  parameter int WIDTH = 10,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;

  // Write port plus registered read; the read samples mem before the write lands.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_reg <= mem[rd_addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/mode_record.sv
// Melody recorder: encodes the live key, measures how long each
// note/octave is held in units of SECOND ticks, and stores
// {note, octave, time} entries terminated by an end marker.
// Optional feature: define REC_LED_EN to echo the captured note on led_out.
module mode_record #(
  parameter int SECOND    = 10000000,
  parameter int SONG_TIME = music_pkg::SONG_TIME
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] key_in,
  input  logic [1:0] octave_in,
  input  logic       rec_start,
  input  logic       rec_stop,
  input  logic [5:0] rd_addr,
  output logic [3:0] rd_note,
  output logic [1:0] rd_octave,
  output logic [3:0] rd_time,
  output logic [5:0] rec_len,
  output logic       recording,
  output logic       full,
  output logic [6:0] led_out
);

  import music_pkg::*;

  localparam int TICK_W = (SECOND > 1) ? $clog2(SECOND) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SECOND - 1);
  // The cycle that opens an entry already counts as its first tick.
  localparam logic [TICK_W-1:0] TICK_OPEN  = (SECOND > 1) ? TICK_W'(1) : '0;
  localparam logic [3:0]        UNITS_OPEN = (SECOND > 1) ? 4'd0 : 4'd1;
  localparam logic [5:0]        LEN_LAST   = 6'(SONG_TIME - 1);

  logic [3:0]        note_enc;
  logic              start_edge;
  logic              stop_edge;
  logic              entry_change;

  state_t            state_reg;
  logic              start_prev_reg;
  logic              stop_prev_reg;
  logic [5:0]        wr_ptr_reg;
  logic [5:0]        rec_len_reg;
  logic              full_reg;
  logic              recording_reg;
  logic [TICK_W-1:0] tick_reg;
  logic [3:0]        units_reg;
  logic [3:0]        cur_note_reg;
  logic [1:0]        cur_oct_reg;
  logic              wr_en_reg;
  logic [5:0]        wr_addr_reg;
  logic [9:0]        wr_data_reg;

  logic              rd_clear_reg;
  logic              rd_end_reg;
  logic [9:0]        ram_rd_data;
  logic [9:0]        rd_word;

  assign note_enc     = encode_note(key_in);
  assign start_edge   = rec_start & ~start_prev_reg;
  assign stop_edge    = rec_stop & ~stop_prev_reg;
  assign entry_change = (note_enc != cur_note_reg) || (octave_in != cur_oct_reg);

  // Recording FSM: edge detection, entry timing and the registered write stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      start_prev_reg <= 1'b0;
      stop_prev_reg  <= 1'b0;
      wr_ptr_reg     <= '0;
      rec_len_reg    <= '0;
      full_reg       <= 1'b0;
      recording_reg  <= 1'b0;
      tick_reg       <= '0;
      units_reg      <= '0;
      cur_note_reg   <= music0;
      cur_oct_reg    <= 2'd0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
    end else begin
      start_prev_reg <= rec_start;
      stop_prev_reg  <= rec_stop;
      wr_en_reg      <= 1'b0;
      case (state_reg)
        IDLE: begin
          // A simultaneous stop edge cancels the start.
          if (start_edge && !stop_edge) begin
            state_reg     <= WAIT_FIRST;
            wr_ptr_reg    <= '0;
            rec_len_reg   <= '0;
            full_reg      <= 1'b0;
            recording_reg <= 1'b1;
          end
        end
        WAIT_FIRST: begin
          if (stop_edge) begin
            state_reg     <= IDLE;
            recording_reg <= 1'b0;
          end else if (note_enc != music0) begin
            state_reg    <= CAPTURE;
            cur_note_reg <= note_enc;
            cur_oct_reg  <= octave_in;
            tick_reg     <= TICK_OPEN;
            units_reg    <= UNITS_OPEN;
          end
        end
        CAPTURE: begin
          if (stop_edge || entry_change) begin
            wr_en_reg   <= 1'b1;
            wr_addr_reg <= wr_ptr_reg;
            wr_data_reg <= {cur_note_reg, cur_oct_reg,
                            (units_reg == 4'd0) ? 4'd1 : units_reg};
            wr_ptr_reg  <= wr_ptr_reg + 6'd1;
            rec_len_reg <= rec_len_reg + 6'd1;
            if (stop_edge || (rec_len_reg + 6'd1 == LEN_LAST)) begin
              state_reg     <= FINISH;
              recording_reg <= 1'b0;
              full_reg      <= (rec_len_reg + 6'd1 == LEN_LAST);
            end else begin
              cur_note_reg <= note_enc;
              cur_oct_reg  <= octave_in;
              tick_reg     <= TICK_OPEN;
              units_reg    <= UNITS_OPEN;
            end
          end else if (tick_reg == TICK_LAST) begin
            tick_reg <= '0;
            if (units_reg != 4'd15) begin
              units_reg <= units_reg + 4'd1;
            end
          end else begin
            tick_reg <= tick_reg + TICK_W'(1);
          end
        end
        FINISH: begin
          wr_en_reg   <= 1'b1;
          wr_addr_reg <= wr_ptr_reg;
          wr_data_reg <= {END_MARK, 2'd0, 4'd0};
          state_reg   <= IDLE;
        end
        default: begin
          state_reg     <= IDLE;
          recording_reg <= 1'b0;
        end
      endcase
    end
  end

  record_buffer #(
    .DEPTH (SONG_TIME),
    .WIDTH (10),
    .AW    (6)
  ) u_record_buffer (
    .clk     (clk),
    .wr_en   (wr_en_reg),
    .wr_addr (wr_addr_reg),
    .wr_data (wr_data_reg),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

  // Read-side qualifiers, aligned with the registered RAM output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_clear_reg <= 1'b1;
      rd_end_reg   <= 1'b0;
    end else begin
      rd_clear_reg <= 1'b0;
      rd_end_reg   <= (rd_addr >= rec_len_reg);
    end
  end

  // Select cleared, end-marker or stored word for the read outputs.
  always_comb begin
    rd_word = ram_rd_data;
    if (rd_clear_reg) begin
      rd_word = '0;
    end else if (rd_end_reg) begin
      rd_word = {END_MARK, 2'd0, 4'd0};
    end
  end

  assign {rd_note, rd_octave, rd_time} = rd_word;
  assign rec_len   = rec_len_reg;
  assign recording = recording_reg;
  assign full      = full_reg;

`ifdef REC_LED_EN
  logic [6:0] led_reg;

  // Echo the note being captured; dark outside CAPTURE and for rests.
  always_ff @(posedge clk) begin
    if (!reset) begin
      led_reg <= '0;
    end else begin
      led_reg <= (state_reg == CAPTURE) ? note_to_led(cur_note_reg) : 7'b0000000;
    end
  end

  assign led_out = led_reg;
`else
  assign led_out = 7'b0000000;
`endif

endmodule

// File: tb/tb_mode_record.sv
// Directed bench for mode_record with SECOND=4.
module tb_mode_record;

  localparam logic [9:0] MARK = {4'b1111, 2'd0, 4'd0};

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] key_in;
  logic [1:0] octave_in;
  logic       rec_start;
  logic       rec_stop;
  logic [5:0] rd_addr;
  logic [3:0] rd_note;
  logic [1:0] rd_octave;
  logic [3:0] rd_time;
  logic [5:0] rec_len;
  logic       recording;
  logic       full;
  logic [6:0] led_out;

  int checks   = 0;
  int failures = 0;

  mode_record #(
    .SECOND    (4),
    .SONG_TIME (56)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_in    (key_in),
    .octave_in (octave_in),
    .rec_start (rec_start),
    .rec_stop  (rec_stop),
    .rd_addr   (rd_addr),
    .rd_note   (rd_note),
    .rd_octave (rd_octave),
    .rd_time   (rd_time),
    .rec_len   (rec_len),
    .recording (recording),
    .full      (full),
    .led_out   (led_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    rec_start = 1'b1;
    step(1);
    rec_start = 1'b0;
  endtask

  task automatic pulse_stop();
    rec_stop = 1'b1;
    key_in   = 7'b0000000;
    step(1);
    rec_stop = 1'b0;
  endtask

  task automatic read_entry(input logic [5:0] a, output logic [9:0] w);
    rd_addr = a;
    step(1);
    w = {rd_note, rd_octave, rd_time};
    $display("read addr=%0d note=%0d octave=%0d time=%0d", a, rd_note, rd_octave, rd_time);
  endtask

  task automatic test_reset();
    logic [9:0] w;
    reset = 1'b0; key_in = '0; octave_in = '0;
    rec_start = 1'b0; rec_stop = 1'b0; rd_addr = '0;
    step(2);
    checks++; if (rec_len !== 6'd0) begin failures++; $display("FAIL reset_rec_len got=%0d exp=0", rec_len); end
    checks++; if (recording !== 1'b0) begin failures++; $display("FAIL reset_recording got=%0b exp=0", recording); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
    checks++; if (led_out !== 7'd0) begin failures++; $display("FAIL reset_led got=%b exp=0000000", led_out); end
    checks++; if ({rd_note, rd_octave, rd_time} !== 10'd0) begin failures++; $display("FAIL reset_rd got=%h exp=000", {rd_note, rd_octave, rd_time}); end
    reset = 1'b1;
    read_entry(6'd0, w);
    checks++; if (w !== MARK) begin failures++; $display("FAIL reset_read0 got=%h exp=%h", w, MARK); end
    $display("test_reset done");
  endtask

  task automatic test_single_note();
    logic [9:0] w;
    octave_in = 2'd2;
    pulse_start();
    checks++; if (recording !== 1'b1) begin failures++; $display("FAIL single_recording got=%0b exp=1", recording); end
    key_in = 7'b0000000;
    step(3);
    checks++; if (rec_len !== 6'd0) begin failures++; $display("FAIL single_leading_rest rec_len got=%0d exp=0", rec_len); end
    key_in = 7'b0000001;
    step(12);
`ifdef REC_LED_EN
    checks++; if (led_out !== 7'b0000001) begin failures++; $display("FAIL single_led got=%b exp=0000001", led_out); end
`else
    checks++; if (led_out !== 7'b0000000) begin failures++; $display("FAIL single_led got=%b exp=0000000", led_out); end
`endif
    pulse_stop();
    checks++; if (rec_len !== 6'd1) begin failures++; $display("FAIL single_rec_len got=%0d exp=1", rec_len); end
    checks++; if (recording !== 1'b0) begin failures++; $display("FAIL single_recording_end got=%0b exp=0", recording); end
    step(3);
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL single_full got=%0b exp=0", full); end
    read_entry(6'd0, w);
    checks++; if (w !== {4'd1, 2'd2, 4'd3}) begin failures++; $display("FAIL single_entry0 got=%h exp=%h", w, {4'd1, 2'd2, 4'd3}); end
    read_entry(6'd1, w);
    checks++; if (w !== MARK) begin failures++; $display("FAIL single_entry1 got=%h exp=%h", w, MARK); end
    $display("test_single_note done");
  endtask

  task automatic test_note_change();
    logic [9:0] w;
    octave_in = 2'd1;
    pulse_start();
    key_in = 7'b0000100;
    step(4);
    rec_start = 1'b1;          // start edge while recording must be ignored
    step(1);
    rec_start = 1'b0;
    step(3);
    key_in = 7'b0010000;
    step(2);
    pulse_stop();
    step(3);
    checks++; if (rec_len !== 6'd2) begin failures++; $display("FAIL change_rec_len got=%0d exp=2", rec_len); end
    read_entry(6'd0, w);
    checks++; if (w !== {4'd3, 2'd1, 4'd2}) begin failures++; $display("FAIL change_entry0 got=%h exp=%h", w, {4'd3, 2'd1, 4'd2}); end
    read_entry(6'd1, w);
    checks++; if (w !== {4'd5, 2'd1, 4'd1}) begin failures++; $display("FAIL change_entry1 got=%h exp=%h", w, {4'd5, 2'd1, 4'd1}); end
    read_entry(6'd2, w);
    checks++; if (w !== MARK) begin failures++; $display("FAIL change_entry2 got=%h exp=%h", w, MARK); end
    $display("test_note_change done");
  endtask

  task automatic test_encode_saturate();
    logic [9:0] w;
    octave_in = 2'd0;
    pulse_start();
    key_in = 7'b0000110;       // two keys: lowest (note 2) wins
    step(4);
    octave_in = 2'd3;          // octave change closes the entry
    step(80);
    key_in = 7'b0000000;       // rest is recorded as its own entry
    step(2);
    pulse_stop();
    step(3);
    checks++; if (rec_len !== 6'd3) begin failures++; $display("FAIL sat_rec_len got=%0d exp=3", rec_len); end
    read_entry(6'd0, w);
    checks++; if (w !== {4'd2, 2'd0, 4'd1}) begin failures++; $display("FAIL sat_entry0 got=%h exp=%h", w, {4'd2, 2'd0, 4'd1}); end
    read_entry(6'd1, w);
    checks++; if (w !== {4'd2, 2'd3, 4'd15}) begin failures++; $display("FAIL sat_entry1 got=%h exp=%h", w, {4'd2, 2'd3, 4'd15}); end
    read_entry(6'd2, w);
    checks++; if (w !== {4'd0, 2'd3, 4'd1}) begin failures++; $display("FAIL sat_entry2 got=%h exp=%h", w, {4'd0, 2'd3, 4'd1}); end
    $display("test_encode_saturate done");
  endtask

  task automatic test_full();
    logic [9:0] w;
    octave_in = 2'd1;
    pulse_start();
    for (int i = 0; i < 55; i++) begin
      key_in = (i % 2 == 1) ? 7'b0000010 : 7'b0000001;
      step(1);
    end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_early got=%0b exp=0", full); end
    checks++; if (rec_len !== 6'd54) begin failures++; $display("FAIL full_len54 got=%0d exp=54", rec_len); end
    key_in = 7'b0000010;
    step(1);
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_flag got=%0b exp=1", full); end
    checks++; if (rec_len !== 6'd55) begin failures++; $display("FAIL full_len55 got=%0d exp=55", rec_len); end
    key_in = 7'b0000000;
    step(1);
    checks++; if (recording !== 1'b0) begin failures++; $display("FAIL full_recording got=%0b exp=0", recording); end
    step(2);
    read_entry(6'd0, w);
    checks++; if (w !== {4'd1, 2'd1, 4'd1}) begin failures++; $display("FAIL full_entry0 got=%h exp=%h", w, {4'd1, 2'd1, 4'd1}); end
    read_entry(6'd1, w);
    checks++; if (w !== {4'd2, 2'd1, 4'd1}) begin failures++; $display("FAIL full_entry1 got=%h exp=%h", w, {4'd2, 2'd1, 4'd1}); end
    read_entry(6'd54, w);
    checks++; if (w !== {4'd1, 2'd1, 4'd1}) begin failures++; $display("FAIL full_entry54 got=%h exp=%h", w, {4'd1, 2'd1, 4'd1}); end
    read_entry(6'd55, w);
    checks++; if (w !== MARK) begin failures++; $display("FAIL full_entry55 got=%h exp=%h", w, MARK); end
    $display("test_full done");
  endtask

  task automatic test_reset_mid();
    logic [9:0] w;
    octave_in = 2'd0;
    pulse_start();
    key_in = 7'b0000001;
    step(6);
    checks++; if (recording !== 1'b1) begin failures++; $display("FAIL mid_recording_before got=%0b exp=1", recording); end
    reset = 1'b0;
    step(1);
    checks++; if (rec_len !== 6'd0) begin failures++; $display("FAIL mid_rec_len got=%0d exp=0", rec_len); end
    checks++; if (recording !== 1'b0) begin failures++; $display("FAIL mid_recording got=%0b exp=0", recording); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL mid_full got=%0b exp=0", full); end
    reset  = 1'b1;
    key_in = 7'b0000000;
    rd_addr = 6'd0;
    step(1);
    checks++; if (rd_note !== 4'b1111) begin failures++; $display("FAIL mid_rd_note got=%b exp=1111", rd_note); end
    read_entry(6'd3, w);
    checks++; if (w !== MARK) begin failures++; $display("FAIL mid_entry3 got=%h exp=%h", w, MARK); end
    $display("test_reset_mid done");
  endtask

  task automatic test_start_stop_same();
    logic [9:0] w;
    octave_in = 2'd0;
    pulse_start();
    key_in = 7'b0000001;
    step(4);
    pulse_stop();
    step(3);
    checks++; if (rec_len !== 6'd1) begin failures++; $display("FAIL same_setup_len got=%0d exp=1", rec_len); end
    rec_start = 1'b1;
    rec_stop  = 1'b1;
    step(1);
    rec_start = 1'b0;
    rec_stop  = 1'b0;
    checks++; if (recording !== 1'b0) begin failures++; $display("FAIL same_recording got=%0b exp=0", recording); end
    step(2);
    checks++; if (rec_len !== 6'd1) begin failures++; $display("FAIL same_rec_len got=%0d exp=1", rec_len); end
    read_entry(6'd0, w);
    checks++; if (w !== {4'd1, 2'd0, 4'd1}) begin failures++; $display("FAIL same_entry0 got=%h exp=%h", w, {4'd1, 2'd0, 4'd1}); end
    $display("test_start_stop_same done");
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_note_change();
    test_encode_saturate();
    test_full();
    test_reset_mid();
    test_start_stop_same();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
